// File: rtl/modport_mem.sv
// Word-addressed memory on a shared tri-state bus.
// Per-word valid bits make unwritten or reset words read as zero.
module modport_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [IDX_W-1:0]  idx;
  logic              hit;
  logic              we;
  logic              drive;
  logic [DATA_W-1:0] rdata;

  assign hit = {1'b0, addr} < LIMIT;
  assign idx = IDX_W'(addr);
  assign we  = wr & hit;

  // Words are never cleared; dropping the valid bits hides them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we) begin
      valid[idx] <= 1'b1;
      mem[idx]   <= data;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit && valid[idx]) rdata = mem[idx];
  end

  // Write wins over read: the bus belongs to the writer.
  assign drive = rd & ~wr & rst_n;
  assign data  = drive ? rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_modport_mem.sv
// Randomized bench for modport_mem against an associative-array model.
// The bus is pulled high, so an undriven bus reads as 16'hFFFF.
module tb_modport_mem;

  localparam logic [15:0] HIZ = 16'hFFFF;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        rd;
  logic        wr;
  logic [15:0] drv;
  logic        drv_en;
  tri1  [15:0] data;

  int n_cmp;
  int n_bad;

  logic [15:0] ref_mem [int];

  assign data = drv_en ? drv : 16'hzzzz;

  modport_mem #(
    .DATA_W(16),
    .ADDR_W(16),
    .DEPTH (256)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data),
    .addr (addr),
    .rd   (rd),
    .wr   (wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    if (a < 16'd256 && ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 16'h0000;
  endfunction

  task automatic do_write(input logic [15:0] a,
                          input logic [15:0] d,
                          input bit rd_too);
    addr = a; drv = d; drv_en = 1'b1; wr = 1'b1; rd = rd_too;
    @(negedge clk);
    if (rd_too) chk("rdwr_bus", data, d);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; drv_en = 1'b0;
    if (a < 16'd256) ref_mem[int'(a)] = d;
  endtask

  task automatic do_read(input string tag, input logic [15:0] a);
    addr = a; rd = 1'b1;
    @(negedge clk);
    chk(tag, data, exp_rd(a));
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic do_read2(input logic [15:0] a, input logic [15:0] b);
    addr = a; rd = 1'b1;
    @(negedge clk);
    chk("rnd_rd", data, exp_rd(a));
    addr = b;
    #1 chk("rnd_rd_track", data, exp_rd(b));
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic do_idle(input string tag);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk(tag, data, HIZ);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1 chk("rnd_rst_hiz", data, HIZ);
    ref_mem.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    int          op;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0;
    drv = '0; drv_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rd = 1'b1; addr = 16'h0005;
    #1 chk("reset_bus_hiz", data, HIZ);
    rd = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_read("reset_rd_5", 16'h0005);

    do_write(16'h0010, 16'hA5A5, 1'b0);
    do_read("rd_10", 16'h0010);
    do_idle("idle_hiz");

    do_write(16'h0003, 16'h1111, 1'b0);
    do_write(16'h0003, 16'h2222, 1'b0);
    do_read("last_wr_3", 16'h0003);
    do_read("unwritten_4", 16'h0004);

    do_write(16'h0100, 16'hBEEF, 1'b0);
    do_read("oob_rd_100", 16'h0100);
    do_read("oob_keep_00", 16'h0000);
    do_read("oob_keep_10", 16'h0010);
    do_read("oob_keep_03", 16'h0003);
    do_write(16'h00FF, 16'h7E7E, 1'b0);
    do_read("last_word_ff", 16'h00FF);

    do_write(16'h0020, 16'h5A5A, 1'b1);
    do_read("rdwr_later_20", 16'h0020);

    // rd+wr with nobody driving: the DUT must stay off the bus
    do_write(16'h0030, 16'h1234, 1'b0);
    addr = 16'h0030; rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    chk("rdwr_no_drive", data, HIZ);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    ref_mem[32'h30] = HIZ;
    do_write(16'h0030, 16'h0F0F, 1'b0);
    do_read("rd_30", 16'h0030);

    do_write(16'h0007, 16'hCAFE, 1'b0);
    addr = 16'h0007; rd = 1'b1;
    #2 chk("pre_rst_rd_7", data, 16'hCAFE);
    rst_n = 1'b0;
    #1 chk("async_rst_hiz", data, HIZ);
    ref_mem.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rd_7", data, 16'h0000);
    @(posedge clk); #1;
    rd = 1'b0;
    do_read("post_rst_rd_10", 16'h0010);

    rst_n = 1'b0;
    addr = 16'h0009; drv = 16'h7777; drv_en = 1'b1; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; drv_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read("rst_abort_wr_9", 16'h0009);

    for (int i = 0; i < 500; i++) begin
      op = int'($urandom_range(0, 19));
      a = ($urandom_range(0, 3) == 0) ? 16'(250 + $urandom_range(0, 10))
                                       : 16'($urandom_range(0, 31));
      b = 16'($urandom_range(0, 31));
      d = 16'($urandom);
      if (op < 8)       do_write(a, d, 1'b0);
      else if (op < 10) do_write(a, d, 1'b1);
      else if (op < 17) do_read2(a, b);
      else if (op < 19) do_idle("rnd_idle");
      else              pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
